// File: rtl/rx_ack_nak_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rx_ack_nak_scheduler
// Description : RX data-link sequence checker and ACK/NAK request scheduler.
//               Optional statistics ports are enabled by RX_ACKNAK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_ack_nak_scheduler #(
    parameter int SEQ_NUM_WIDTH = 12,
    parameter int ACK_LATENCY   = 255,
    parameter int ACK_COALESCE  = 4,
    parameter int TIMER_WIDTH   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     DL_Down,
    input  logic                     rx_tlp_end,
    input  logic [SEQ_NUM_WIDTH-1:0] rx_seq_num,
    input  logic                     rx_lcrc_ok,
    input  logic                     dllp_gnt,
    output logic                     tlp_accept,
    output logic                     tlp_discard,
    output logic                     gen_ack,
    output logic                     gen_nak,
    output logic [SEQ_NUM_WIDTH-1:0] ack_nak_seq_num,
    output logic [SEQ_NUM_WIDTH-1:0] nrs,
    output logic                     nak_scheduled
`ifdef RX_ACKNAK_STATS_EN
    ,
    output logic [15:0]              stat_nak_cnt,
    output logic [15:0]              stat_dup_cnt
`endif
);

    localparam int PEND_WIDTH = $clog2(ACK_COALESCE + 1);
    localparam logic [SEQ_NUM_WIDTH-1:0] HALF_RANGE = {1'b1, {(SEQ_NUM_WIDTH-1){1'b0}}};
    localparam logic [TIMER_WIDTH-1:0]   TIMER_LAST = TIMER_WIDTH'(ACK_LATENCY - 1);
    localparam logic [PEND_WIDTH-1:0]    PEND_MAX   = PEND_WIDTH'(ACK_COALESCE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK_WAIT = 2'd1,
        S_ACK_REQ  = 2'd2,
        S_NAK_REQ  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [SEQ_NUM_WIDTH-1:0] nrs_q, nrs_d;
    logic [PEND_WIDTH-1:0]    pend_cnt_q, pend_cnt_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic                     nak_sched_q, nak_sched_d;
    logic                     tlp_accept_q, tlp_accept_d;
    logic                     tlp_discard_q, tlp_discard_d;
    logic                     gen_ack_q, gen_ack_d;
    logic                     gen_nak_q, gen_nak_d;

    logic                     w_rx_valid;
    logic [SEQ_NUM_WIDTH-1:0] w_seq_dist;
    logic                     w_is_bad, w_is_acc, w_is_dup, w_is_ahead, w_nak_evt;
    logic                     w_req_pending;

    // Distance behind NRS: 0 = expected, 1..half = already received, else ahead.
    assign w_rx_valid    = rx_tlp_end && !DL_Down;
    assign w_seq_dist    = nrs_q - rx_seq_num;
    assign w_is_bad      = w_rx_valid && !rx_lcrc_ok;
    assign w_is_acc      = w_rx_valid && rx_lcrc_ok && (w_seq_dist == '0);
    assign w_is_dup      = w_rx_valid && rx_lcrc_ok && (w_seq_dist != '0) && (w_seq_dist <= HALF_RANGE);
    assign w_is_ahead    = w_rx_valid && rx_lcrc_ok && (w_seq_dist > HALF_RANGE);
    assign w_nak_evt     = (w_is_bad || w_is_ahead) && !nak_sched_q;
    assign w_req_pending = (state_q == S_ACK_REQ) || (state_q == S_NAK_REQ);

    always_comb begin
        state_d       = state_q;
        nrs_d         = nrs_q;
        pend_cnt_d    = pend_cnt_q;
        timer_d       = timer_q;
        nak_sched_d   = nak_sched_q;
        tlp_accept_d  = w_is_acc;
        tlp_discard_d = w_is_bad || w_is_dup || w_is_ahead;

        if (state_q == S_ACK_WAIT) begin
            if (timer_q != '1) begin
                timer_d = timer_q + TIMER_WIDTH'(1);
            end
            if ((timer_q == TIMER_LAST) || (pend_cnt_q >= PEND_MAX)) begin
                state_d = S_ACK_REQ;
            end
        end

        if (dllp_gnt && w_req_pending) begin
            state_d    = S_IDLE;
            pend_cnt_d = '0;
            timer_d    = '0;
        end

        if (w_is_acc) begin
            nrs_d       = nrs_q + SEQ_NUM_WIDTH'(1);
            nak_sched_d = 1'b0;
            if (pend_cnt_d != PEND_MAX) begin
                pend_cnt_d = pend_cnt_d + PEND_WIDTH'(1);
            end
            if (state_d == S_IDLE) begin
                state_d = S_ACK_WAIT;
                timer_d = '0;
            end
        end

        // A pending NAK already acknowledges NRS-1, so a duplicate leaves it alone.
        if (w_is_dup && (state_d != S_NAK_REQ)) begin
            state_d = S_ACK_REQ;
        end

        if (w_nak_evt) begin
            nak_sched_d = 1'b1;
            state_d     = S_NAK_REQ;
        end

        if (DL_Down) begin
            state_d       = S_IDLE;
            nrs_d         = '0;
            pend_cnt_d    = '0;
            timer_d       = '0;
            nak_sched_d   = 1'b0;
            tlp_accept_d  = 1'b0;
            tlp_discard_d = 1'b0;
        end

        gen_ack_d = (state_d == S_ACK_REQ);
        gen_nak_d = (state_d == S_NAK_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            nrs_q         <= '0;
            pend_cnt_q    <= '0;
            timer_q       <= '0;
            nak_sched_q   <= 1'b0;
            tlp_accept_q  <= 1'b0;
            tlp_discard_q <= 1'b0;
            gen_ack_q     <= 1'b0;
            gen_nak_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            nrs_q         <= nrs_d;
            pend_cnt_q    <= pend_cnt_d;
            timer_q       <= timer_d;
            nak_sched_q   <= nak_sched_d;
            tlp_accept_q  <= tlp_accept_d;
            tlp_discard_q <= tlp_discard_d;
            gen_ack_q     <= gen_ack_d;
            gen_nak_q     <= gen_nak_d;
        end
    end

    assign tlp_accept      = tlp_accept_q;
    assign tlp_discard     = tlp_discard_q;
    assign gen_ack         = gen_ack_q;
    assign gen_nak         = gen_nak_q;
    assign nrs             = nrs_q;
    assign nak_scheduled   = nak_sched_q;
    assign ack_nak_seq_num = nrs_q - SEQ_NUM_WIDTH'(1);

`ifdef RX_ACKNAK_STATS_EN
    logic [15:0] stat_nak_cnt_q, stat_nak_cnt_d;
    logic [15:0] stat_dup_cnt_q, stat_dup_cnt_d;

    always_comb begin
        stat_nak_cnt_d = stat_nak_cnt_q;
        stat_dup_cnt_d = stat_dup_cnt_q;
        if (dllp_gnt && (state_q == S_NAK_REQ) && (stat_nak_cnt_q != 16'hFFFF)) begin
            stat_nak_cnt_d = stat_nak_cnt_q + 16'd1;
        end
        if (w_is_dup && (stat_dup_cnt_q != 16'hFFFF)) begin
            stat_dup_cnt_d = stat_dup_cnt_q + 16'd1;
        end
        if (DL_Down) begin
            stat_nak_cnt_d = '0;
            stat_dup_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_nak_cnt_q <= '0;
            stat_dup_cnt_q <= '0;
        end else begin
            stat_nak_cnt_q <= stat_nak_cnt_d;
            stat_dup_cnt_q <= stat_dup_cnt_d;
        end
    end

    assign stat_nak_cnt = stat_nak_cnt_q;
    assign stat_dup_cnt = stat_dup_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_ack_nak_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_ack_nak_scheduler
// Description : Directed self-checking bench for rx_ack_nak_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_ack_nak_scheduler;

    localparam int W   = 12;
    localparam int LAT = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         DL_Down = 1'b0;
    logic         rx_tlp_end = 1'b0;
    logic [W-1:0] rx_seq_num = '0;
    logic         rx_lcrc_ok = 1'b0;
    logic         dllp_gnt = 1'b0;
    logic         tlp_accept, tlp_discard, gen_ack, gen_nak, nak_scheduled;
    logic [W-1:0] ack_nak_seq_num, nrs;
`ifdef RX_ACKNAK_STATS_EN
    logic [15:0]  stat_nak_cnt, stat_dup_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rx_ack_nak_scheduler #(
        .SEQ_NUM_WIDTH(W), .ACK_LATENCY(LAT), .ACK_COALESCE(4), .TIMER_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .DL_Down(DL_Down),
        .rx_tlp_end(rx_tlp_end), .rx_seq_num(rx_seq_num), .rx_lcrc_ok(rx_lcrc_ok),
        .dllp_gnt(dllp_gnt), .tlp_accept(tlp_accept), .tlp_discard(tlp_discard),
        .gen_ack(gen_ack), .gen_nak(gen_nak), .ack_nak_seq_num(ack_nak_seq_num),
        .nrs(nrs), .nak_scheduled(nak_scheduled)
`ifdef RX_ACKNAK_STATS_EN
        , .stat_nak_cnt(stat_nak_cnt), .stat_dup_cnt(stat_dup_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] seq, input logic ok);
        rx_tlp_end = 1'b1;
        rx_seq_num = seq;
        rx_lcrc_ok = ok;
        tick(1);
        rx_tlp_end = 1'b0;
    endtask

    task automatic grant();
        dllp_gnt = 1'b1;
        tick(1);
        dllp_gnt = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1);
        checks++; if ({tlp_accept, tlp_discard, gen_ack, gen_nak, nak_scheduled} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b want 00000", {tlp_accept, tlp_discard, gen_ack, gen_nak, nak_scheduled}); end
        checks++; if (ack_nak_seq_num !== 12'hFFF) begin errors++; $display("FAIL reset_acknak_seq got %h want fff", ack_nak_seq_num); end
        checks++; if (nrs !== 12'h000) begin errors++; $display("FAIL reset_nrs got %h want 000", nrs); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_latency();
        int n;
        do_reset();
        send(12'd0, 1'b1);
        checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL lat_accept0 got %b want 1", tlp_accept); end
        send(12'd1, 1'b1);
        send(12'd2, 1'b1);
        checks++; if (tlp_accept !== 1'b1) begin errors++; $display("FAIL lat_accept2 got %b want 1", tlp_accept); end
        // First accept became visible two edges ago; gen_ack is due LAT edges after it.
        n = 0;
        while (gen_ack !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        checks++; if (n != LAT - 2) begin errors++; $display("FAIL lat_timer got %0d cycles want %0d", n, LAT - 2); end
        checks++; if (ack_nak_seq_num !== 12'd2) begin errors++; $display("FAIL lat_seq got %0d want 2", ack_nak_seq_num); end
        grant();
        checks++; if ({gen_ack, gen_nak} !== 2'b00) begin errors++; $display("FAIL lat_gnt_idle got %b want 00", {gen_ack, gen_nak}); end
        tick(3);
        checks++; if (gen_ack !== 1'b0) begin errors++; $display("FAIL lat_stay_idle got %b want 0", gen_ack); end
    endtask

    task automatic test_coalesce();
        do_reset();
        for (int i = 0; i < 4; i++) send(W'(i), 1'b1);
        checks++; if (gen_ack !== 1'b0) begin errors++; $display("FAIL coal_early got %b want 0", gen_ack); end
        tick(1);
        checks++; if (gen_ack !== 1'b1) begin errors++; $display("FAIL coal_ack got %b want 1", gen_ack); end
        checks++; if (ack_nak_seq_num !== 12'd3) begin errors++; $display("FAIL coal_seq got %0d want 3", ack_nak_seq_num); end
        grant();
    endtask

    task automatic test_bad_lcrc();
        do_reset();
        for (int i = 0; i < 5; i++) send(W'(i), 1'b1);
        grant();
        checks++; if (nrs !== 12'd5) begin errors++; $display("FAIL nak_setup_nrs got %0d want 5", nrs); end
        send(12'd5, 1'b0);
        checks++; if ({tlp_discard, tlp_accept} !== 2'b10) begin errors++; $display("FAIL nak_discard got %b want 10", {tlp_discard, tlp_accept}); end
        checks++; if ({gen_nak, gen_ack, nak_scheduled} !== 3'b101) begin errors++; $display("FAIL nak_req got %b want 101", {gen_nak, gen_ack, nak_scheduled}); end
        checks++; if (ack_nak_seq_num !== 12'd4) begin errors++; $display("FAIL nak_seq got %0d want 4", ack_nak_seq_num); end
        grant();
        checks++; if (gen_nak !== 1'b0) begin errors++; $display("FAIL nak_gnt got %b want 0", gen_nak); end
        send(12'd5, 1'b0);
        checks++; if ({tlp_discard, gen_nak} !== 2'b10) begin errors++; $display("FAIL nak_second got %b want 10", {tlp_discard, gen_nak}); end
        send(12'd5, 1'b1);
        checks++; if ({tlp_accept, nak_scheduled} !== 2'b10) begin errors++; $display("FAIL nak_recover got %b want 10", {tlp_accept, nak_scheduled}); end
        checks++; if (nrs !== 12'd6) begin errors++; $display("FAIL nak_nrs got %0d want 6", nrs); end
`ifdef RX_ACKNAK_STATS_EN
        checks++; if (stat_nak_cnt !== 16'd1 || stat_dup_cnt !== 16'd0) begin errors++; $display("FAIL nak_stats got %0d/%0d want 1/0", stat_nak_cnt, stat_dup_cnt); end
`endif
    endtask

    task automatic test_wrap_dup();
        do_reset();
        send(12'hFFF, 1'b1);
        checks++; if ({tlp_discard, tlp_accept, gen_ack} !== 3'b101) begin errors++; $display("FAIL wrap_dup got %b want 101", {tlp_discard, tlp_accept, gen_ack}); end
        checks++; if (ack_nak_seq_num !== 12'hFFF || nrs !== 12'd0) begin errors++; $display("FAIL wrap_seq got %h/%h want fff/000", ack_nak_seq_num, nrs); end
        send(12'h800, 1'b1);
        checks++; if ({tlp_discard, gen_ack, gen_nak} !== 3'b110) begin errors++; $display("FAIL half_dup got %b want 110", {tlp_discard, gen_ack, gen_nak}); end
        send(12'h7FF, 1'b1);
        checks++; if ({tlp_discard, gen_nak, gen_ack} !== 3'b110) begin errors++; $display("FAIL ahead_edge got %b want 110", {tlp_discard, gen_nak, gen_ack}); end
`ifdef RX_ACKNAK_STATS_EN
        checks++; if (stat_dup_cnt !== 16'd2) begin errors++; $display("FAIL wrap_stats got %0d want 2", stat_dup_cnt); end
`endif
        grant();
    endtask

    task automatic test_ahead_upgrade();
        do_reset();
        for (int i = 0; i < 10; i++) send(W'(i), 1'b1);
        grant();
        send(12'd12, 1'b1);
        checks++; if ({tlp_discard, gen_nak, gen_ack} !== 3'b110) begin errors++; $display("FAIL ahead_nak got %b want 110", {tlp_discard, gen_nak, gen_ack}); end
        checks++; if (ack_nak_seq_num !== 12'd9) begin errors++; $display("FAIL ahead_seq got %0d want 9", ack_nak_seq_num); end
        grant();
        send(12'd10, 1'b1);
        send(12'd10, 1'b1);
        checks++; if ({gen_ack, gen_nak} !== 2'b10) begin errors++; $display("FAIL dup_ack got %b want 10", {gen_ack, gen_nak}); end
        send(12'd11, 1'b0);
        checks++; if ({gen_nak, gen_ack, tlp_discard} !== 3'b101) begin errors++; $display("FAIL upgrade got %b want 101", {gen_nak, gen_ack, tlp_discard}); end
        checks++; if (ack_nak_seq_num !== 12'd10) begin errors++; $display("FAIL upgrade_seq got %0d want 10", ack_nak_seq_num); end
        grant();
`ifdef RX_ACKNAK_STATS_EN
        checks++; if (stat_nak_cnt !== 16'd2 || stat_dup_cnt !== 16'd1) begin errors++; $display("FAIL upg_stats got %0d/%0d want 2/1", stat_nak_cnt, stat_dup_cnt); end
`endif
    endtask

    task automatic test_dl_down();
        do_reset();
        send(12'd0, 1'b1);
        send(12'd0, 1'b1);
        checks++; if ({gen_ack, nrs} !== {1'b1, 12'd1}) begin errors++; $display("FAIL dl_setup got %b/%0d want 1/1", gen_ack, nrs); end
        DL_Down = 1'b1;
        rx_tlp_end = 1'b1;
        rx_seq_num = 12'd1;
        rx_lcrc_ok = 1'b0;
        tick(1);
        rx_tlp_end = 1'b0;
        DL_Down = 1'b0;
        checks++; if ({gen_ack, gen_nak, nak_scheduled, tlp_accept, tlp_discard} !== 5'b0) begin errors++; $display("FAIL dl_outs got %b want 00000", {gen_ack, gen_nak, nak_scheduled, tlp_accept, tlp_discard}); end
        checks++; if (nrs !== 12'd0 || ack_nak_seq_num !== 12'hFFF) begin errors++; $display("FAIL dl_nrs got %h/%h want 000/fff", nrs, ack_nak_seq_num); end
`ifdef RX_ACKNAK_STATS_EN
        checks++; if (stat_nak_cnt !== 16'd0 || stat_dup_cnt !== 16'd0) begin errors++; $display("FAIL dl_stats got %0d/%0d want 0/0", stat_nak_cnt, stat_dup_cnt); end
`endif
        send(12'd0, 1'b1);
        checks++; if ({tlp_accept, nrs} !== {1'b1, 12'd1}) begin errors++; $display("FAIL dl_resume got %b/%0d want 1/1", tlp_accept, nrs); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_coalesce();
        test_bad_lcrc();
        test_wrap_dup();
        test_ahead_upgrade();
        test_dl_down();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
